// File: rtl/hdmi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : hdmi_pkg                                                   |
// | Purpose : Shared types, widths and elaboration-time helpers for the  |
// |           HDMI scan-out address generators.                          |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package hdmi_pkg;

  localparam int ADDR_W = 32;
  localparam int NUM_W  = 9;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_KICK      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  // Bits needed to hold values 0..value-1 (returns 0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Integer division rounded up; used for the bursts-per-line count.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hdmi_buf_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : hdmi_buf_sel                                               |
// | Purpose : Tracks the newest complete frame buffer, switches the      |
// |           displayed buffer at frame start and latches a frame start  |
// |           that arrives while the fetch engine is mid-line.           |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module hdmi_buf_sel
  import hdmi_pkg::*;
#(
  parameter int NUM_BUF = 2
) (
  input  logic       clk_vga,
  input  logic       rst_n,
  input  logic       framestart,
  input  logic       wr_frame_done,
  input  logic [1:0] wr_buf_idx,
  input  logic       fsm_active,
  input  logic       restart_clr,
  output logic [1:0] rd_buf_idx,
  output logic       restart
);

  localparam logic [2:0] c_num_buf = 3'(NUM_BUF);

  logic [1:0] latest;
  logic       wr_valid;

  // Out-of-range buffer indices are dropped; with one buffer only index 0
  // is ever accepted, so the displayed buffer stays 0.
  assign wr_valid = wr_frame_done && ({1'b0, wr_buf_idx} < c_num_buf);

  // Newest completed buffer, as reported by the writer.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      latest <= 2'd0;
    end else if (wr_valid) begin
      latest <= wr_buf_idx;
    end
  end

  // Displayed buffer changes only at frame start; a completion in the same
  // cycle is taken for the frame that is starting.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      rd_buf_idx <= 2'd0;
    end else if (framestart) begin
      rd_buf_idx <= wr_valid ? wr_buf_idx : latest;
    end
  end

  // Remembers a frame start seen mid-line so the line can be abandoned once
  // the in-flight burst finishes; clear has priority over a new set.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      restart <= 1'b0;
    end else if (restart_clr) begin
      restart <= 1'b0;
    end else if (framestart && fsm_active) begin
      restart <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hdmi_axi_addr_mb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : hdmi_axi_addr_mb                                           |
// | Purpose : Multi-buffer read-address generator for HDMI scan-out.     |
// |           Splits each requested line into bursts of at most          |
// |           MAX_BURST beats and hands them to the AXI read master.     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module hdmi_axi_addr_mb
  import hdmi_pkg::*;
#(
  parameter int          X_SIZE          = 256,
  parameter int          Y_SIZE          = 256,
  parameter int          BYTES_PER_PIXEL = 4,
  parameter int          DATA_BYTES      = 16,
  parameter int          MAX_BURST       = 16,
  parameter int          NUM_BUF         = 2,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter logic [31:0] LINE_STRIDE     = 32'(X_SIZE * BYTES_PER_PIXEL),
  parameter logic [31:0] FRAME_STRIDE    = LINE_STRIDE * 32'(Y_SIZE)
) (
  input  logic              clk_vga,
  input  logic              rst_n,
  input  logic              framestart,
  input  logic              prefetch_line,
  input  logic              wr_frame_done,
  input  logic [1:0]        wr_buf_idx,
  output logic              kick,
  input  logic              busy,
  output logic [ADDR_W-1:0] read_addr,
  output logic [NUM_W-1:0]  read_num,
  output logic [1:0]        rd_buf_idx,
  output logic              overrun
);

  localparam int LINE_BEATS = X_SIZE * BYTES_PER_PIXEL / DATA_BYTES;
  localparam int BURSTS     = ceil_div(LINE_BEATS, MAX_BURST);
  localparam int LAST_BEATS = LINE_BEATS - (BURSTS - 1) * MAX_BURST;
  localparam int Y_W        = clog2(Y_SIZE + 1);
  localparam int BC_W       = clog2(BURSTS + 1);

  localparam logic [NUM_W-1:0]  c_max_num     = NUM_W'(MAX_BURST);
  localparam logic [NUM_W-1:0]  c_last_num    = NUM_W'(LAST_BEATS);
  localparam logic [NUM_W-1:0]  c_first_num   = (BURSTS == 1) ? c_last_num : c_max_num;
  localparam logic [ADDR_W-1:0] c_burst_bytes = ADDR_W'(MAX_BURST * DATA_BYTES);
  localparam logic [Y_W-1:0]    c_y_size      = Y_W'(Y_SIZE);
  localparam logic [BC_W-1:0]   c_bursts_m1   = BC_W'(BURSTS - 1);

  state_t            state;
  logic              pending;
  logic [Y_W-1:0]    y;
  logic [BC_W-1:0]   bursts_left;
  logic              restart;
  logic              restart_clr;
  logic              fsm_active;
  logic              frame_done;
  logic              abort;
  logic [ADDR_W-1:0] line_addr;

  assign fsm_active  = (state != ST_IDLE);
  assign frame_done  = (y == c_y_size);
  assign restart_clr = (state == ST_WAIT_DONE) && !busy;
  // A frame start in the very cycle the burst completes also abandons the line.
  assign abort       = restart || framestart;
  assign line_addr   = BASE_ADDR
                     + ADDR_W'(rd_buf_idx) * FRAME_STRIDE
                     + ADDR_W'(y) * LINE_STRIDE;

  hdmi_buf_sel #(
    .NUM_BUF (NUM_BUF)
  ) u_buf_sel (
    .clk_vga       (clk_vga),
    .rst_n         (rst_n),
    .framestart    (framestart),
    .wr_frame_done (wr_frame_done),
    .wr_buf_idx    (wr_buf_idx),
    .fsm_active    (fsm_active),
    .restart_clr   (restart_clr),
    .rd_buf_idx    (rd_buf_idx),
    .restart       (restart)
  );

  // Burst FSM with line counter, request bookkeeping and registered outputs.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      kick        <= 1'b0;
      read_addr   <= BASE_ADDR;
      read_num    <= '0;
      bursts_left <= '0;
      pending     <= 1'b0;
      y           <= '0;
      overrun     <= 1'b0;
    end else begin
      kick <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Hold off for one cycle on frame start so the new buffer/line apply.
          if (pending && !frame_done && !framestart) begin
            pending     <= 1'b0;
            read_addr   <= line_addr;
            read_num    <= c_first_num;
            bursts_left <= c_bursts_m1;
            kick        <= 1'b1;
            state       <= ST_KICK;
          end
        end
        ST_KICK: begin
          state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (busy) begin
            state <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (!busy) begin
            if (abort) begin
              state <= ST_IDLE;
            end else if (bursts_left != '0) begin
              read_addr   <= read_addr + c_burst_bytes;
              read_num    <= (bursts_left == BC_W'(1)) ? c_last_num : c_max_num;
              bursts_left <= bursts_left - BC_W'(1);
              kick        <= 1'b1;
              state       <= ST_KICK;
            end else begin
              y     <= y + Y_W'(1);
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      // Frame start rewinds the line counter and drops any queued request.
      if (framestart) begin
        y       <= '0;
        pending <= 1'b0;
      end

      // One request may queue behind the line in flight; a second is an overrun.
      if (prefetch_line && !frame_done) begin
        if (pending && fsm_active) begin
          overrun <= 1'b1;
        end else begin
          pending <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_axi_addr_mb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_hdmi_axi_addr_mb                                        |
// | Purpose : Directed self-checking bench for hdmi_axi_addr_mb with     |
// |           MAX_BURST=24 (64-beat lines), three buffers, nonzero base. |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_hdmi_axi_addr_mb;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic       clk_vga = 1'b0;
  logic       rst_n;
  logic       framestart;
  logic       prefetch_line;
  logic       wr_frame_done;
  logic [1:0] wr_buf_idx;
  logic       kick;
  logic       busy;
  logic [31:0] read_addr;
  logic [8:0]  read_num;
  logic [1:0]  rd_buf_idx;
  logic        overrun;

  int checks   = 0;
  int failures = 0;
  int kick_cnt = 0;
  int busy_len = 40;
  int busy_cnt = 0;
  int kc;
  logic [31:0] log_addr[$];
  logic [8:0]  log_num[$];

  hdmi_axi_addr_mb #(
    .X_SIZE          (256),
    .Y_SIZE          (256),
    .BYTES_PER_PIXEL (4),
    .DATA_BYTES      (16),
    .MAX_BURST       (24),
    .NUM_BUF         (3),
    .BASE_ADDR       (BASE),
    .LINE_STRIDE     (32'h0000_0400),
    .FRAME_STRIDE    (32'h0004_0000)
  ) dut (
    .clk_vga       (clk_vga),
    .rst_n         (rst_n),
    .framestart    (framestart),
    .prefetch_line (prefetch_line),
    .wr_frame_done (wr_frame_done),
    .wr_buf_idx    (wr_buf_idx),
    .kick          (kick),
    .busy          (busy),
    .read_addr     (read_addr),
    .read_num      (read_num),
    .rd_buf_idx    (rd_buf_idx),
    .overrun       (overrun)
  );

  always #5 clk_vga = ~clk_vga;

  // Read-master model: busy rises right after a kick and stays high busy_len cycles.
  always @(negedge clk_vga) begin
    if (kick) begin
      busy     = 1'b1;
      busy_cnt = busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
      if (busy_cnt == 0) busy = 1'b0;
    end
  end

  // Kick logger.
  always @(negedge clk_vga) begin
    if (kick) begin
      log_addr.push_back(read_addr);
      log_num.push_back(read_num);
      kick_cnt = kick_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_kicks(input int target, input int budget);
    int n;
    n = 0;
    while (kick_cnt < target && n < budget) begin
      @(negedge clk_vga);
      n = n + 1;
    end
    checks = checks + 1;
    assert (kick_cnt >= target) else begin
      failures = failures + 1;
      $error("FAIL wait_kicks observed=%0d expected=%0d", kick_cnt, target);
    end
    @(negedge clk_vga);
  endtask

  task automatic pulse_prefetch();
    @(negedge clk_vga) prefetch_line = 1'b1;
    @(negedge clk_vga) prefetch_line = 1'b0;
  endtask

  task automatic pulse_wr(input logic [1:0] idx, input logic with_fs);
    @(negedge clk_vga);
    wr_frame_done = 1'b1;
    wr_buf_idx    = idx;
    framestart    = with_fs;
    @(negedge clk_vga);
    wr_frame_done = 1'b0;
    framestart    = 1'b0;
  endtask

  task automatic pulse_fs();
    @(negedge clk_vga) framestart = 1'b1;
    @(negedge clk_vga) framestart = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; framestart = 1'b0; prefetch_line = 1'b0;
    wr_frame_done = 1'b0; wr_buf_idx = 2'd0; busy = 1'b0;
    repeat (3) @(negedge clk_vga);

    // Reset state
    chk("rst_kick", 32'(kick), 32'd0);
    chk("rst_addr", read_addr, BASE);
    chk("rst_num", 32'(read_num), 32'd0);
    chk("rst_buf", 32'(rd_buf_idx), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk_vga) rst_n = 1'b1;
    repeat (2) @(negedge clk_vga);

    // Line 0: two-cycle latency, then bursts 24/24/16 at offsets 0/0x180/0x300
    pulse_prefetch();
    chk("lat_t1_kick", 32'(kick), 32'd0);
    @(negedge clk_vga);
    chk("lat_t2_kick", 32'(kick), 32'd1);
    chk("lat_t2_addr", read_addr, BASE);
    chk("lat_t2_num", 32'(read_num), 32'd24);
    wait_kicks(3, 500);
    chk("l0_b1_addr", log_addr[1], BASE + 32'h180);
    chk("l0_b1_num", 32'(log_num[1]), 32'd24);
    chk("l0_b2_addr", log_addr[2], BASE + 32'h300);
    chk("l0_b2_num", 32'(log_num[2]), 32'd16);
    repeat (60) @(negedge clk_vga);

    // Line 1 follows one stride later
    pulse_prefetch();
    wait_kicks(6, 500);
    chk("l1_addr", log_addr[3], BASE + 32'h400);
    chk("l1_b2_addr", log_addr[5], BASE + 32'h700);
    repeat (60) @(negedge clk_vga);

    // Overrun: third request while one is already queued behind line 2
    pulse_prefetch();
    wait_kicks(7, 100);
    pulse_prefetch();
    pulse_prefetch();
    chk("overrun_set", 32'(overrun), 32'd1);
    wait_kicks(12, 1500);
    repeat (200) @(negedge clk_vga);
    chk("overrun_lines", 32'(kick_cnt), 32'd12);
    chk("l2_addr", log_addr[6], BASE + 32'h800);
    chk("l3_addr", log_addr[9], BASE + 32'hC00);

    // Buffer switch only at frame start; out-of-range index ignored
    pulse_wr(2'd2, 1'b0);
    repeat (3) @(negedge clk_vga);
    chk("buf_hold", 32'(rd_buf_idx), 32'd0);
    pulse_wr(2'd3, 1'b0);
    pulse_fs();
    chk("buf_switch", 32'(rd_buf_idx), 32'd2);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    pulse_prefetch();
    wait_kicks(13, 100);
    chk("buf2_addr", log_addr[12], BASE + 32'h8_0000);

    // Asynchronous reset while waiting for busy to fall
    repeat (5) @(negedge clk_vga);
    @(posedge clk_vga);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_kick", 32'(kick), 32'd0);
    chk("arst_addr", read_addr, BASE);
    chk("arst_overrun", 32'(overrun), 32'd0);
    chk("arst_buf", 32'(rd_buf_idx), 32'd0);
    repeat (2) @(negedge clk_vga);
    rst_n = 1'b1;
    kc = kick_cnt;
    repeat (100) @(negedge clk_vga);
    chk("arst_no_kick", 32'(kick_cnt), 32'(kc));

    // 257 requests in one frame: 256 lines fetched, last ignored silently
    busy_len = 2;
    for (int i = 0; i < 257; i++) begin
      pulse_prefetch();
      repeat (30) @(negedge clk_vga);
    end
    chk("frame_kicks", 32'(kick_cnt - kc), 32'd768);
    chk("frame_overrun", 32'(overrun), 32'd0);
    chk("l255_addr", log_addr[kc + 765], BASE + 32'h3_FC00);
    chk("l255_num", 32'(log_num[kc + 767]), 32'd16);

    // Completion in the same cycle as frame start is used for that frame
    pulse_wr(2'd1, 1'b1);
    chk("same_cycle_buf", 32'(rd_buf_idx), 32'd1);
    pulse_prefetch();
    wait_kicks(kc + 769, 100);
    chk("new_frame_addr", log_addr[kc + 768], BASE + 32'h4_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
